// File: rtl/nios2_mul_seq_arb.sv
// Round-robin sequencer sharing one 16x16 registered multiplier between two 32x32 requesters.
// Optional NIOS2_MUL_SEQ_LOWONLY_SHORT_EN: low-only requests skip the high*high partial product.
module nios2_mul_seq_arb #(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [63:0] resp_result,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p
);

  localparam int unsigned LAST = MUL_LATENCY - 1;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CORR, RESP} state_t;

  state_t      state;
  logic        prio;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op;
  logic        id;
  logic [1:0]  k;
  logic [63:0] acc;
  logic [MUL_LATENCY-1:0] vpipe;
  logic [1:0]  spipe [MUL_LATENCY];

  logic        grant0;
  logic        grant1;
  logic        handshake;
  logic        last_issue;
  logic        drain_done;
  logic [1:0]  k_next;
  logic [31:0] a_sel;
  logic [31:0] b_sel;
  logic [2:0]  op_sel;
  logic [63:0] pp;
  logic [63:0] acc_sum;
  logic [63:0] corr;

  // Round-robin grant; only offered while idle
  always_comb begin
    grant0     = req0_valid && (!prio || !req1_valid);
    grant1     = req1_valid && (prio || !req0_valid);
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    handshake  = req0_ready || req1_ready;
    a_sel      = req1_ready ? req1_a  : req0_a;
    b_sel      = req1_ready ? req1_b  : req0_b;
    op_sel     = req1_ready ? req1_op : req0_op;
  end

  assign k_next = k + 2'd1;

`ifdef NIOS2_MUL_SEQ_LOWONLY_SHORT_EN
  assign last_issue = (k == 2'd3) || (op[2] && (k == 2'd2));
`else
  assign last_issue = (k == 2'd3);
`endif

  // Entry in the last slot exits this cycle, so only the younger slots must be empty
  always_comb begin
    drain_done = 1'b1;
    for (int i = 0; i < int'(LAST); i++) begin
      if (vpipe[i]) drain_done = 1'b0;
    end
  end

  assign pp      = 64'(mul_p) << {spipe[LAST], 4'b0000};
  assign acc_sum = vpipe[LAST] ? (acc + pp) : acc;

  // Unsigned-to-signed correction; high-word terms vanish for low-only results
  always_comb begin
    corr = acc;
    if (op[0] && op_a[31]) corr = corr - {op_b, 32'd0};
    if (op[1] && op_b[31]) corr = corr - {op_a, 32'd0};
    if (op[2]) corr[63:32] = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prio        <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op          <= '0;
      id          <= 1'b0;
      k           <= '0;
      acc         <= '0;
      vpipe       <= '0;
      for (int i = 0; i < int'(MUL_LATENCY); i++) spipe[i] <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      // Shift code 0/1/2 selects a 0/16/32-bit shift when the product returns
      vpipe[0] <= (state == ISSUE);
      spipe[0] <= {k[1] & k[0], k[1] ^ k[0]};
      for (int i = 1; i < int'(MUL_LATENCY); i++) begin
        vpipe[i] <= vpipe[i-1];
        spipe[i] <= spipe[i-1];
      end
      acc <= acc_sum;

      case (state)
        IDLE: begin
          if (handshake) begin
            op_a  <= a_sel;
            op_b  <= b_sel;
            op    <= op_sel;
            id    <= req1_ready;
            prio  <= req0_ready;
            acc   <= '0;
            k     <= '0;
            mul_a <= a_sel[15:0];
            mul_b <= b_sel[15:0];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (last_issue) begin
            mul_a <= '0;
            mul_b <= '0;
            state <= DRAIN;
          end else begin
            k     <= k_next;
            mul_a <= k_next[0] ? op_a[31:16] : op_a[15:0];
            mul_b <= k_next[1] ? op_b[31:16] : op_b[15:0];
          end
        end
        DRAIN: begin
          if (drain_done) state <= CORR;
        end
        CORR: begin
          acc         <= corr;
          resp_result <= corr;
          resp_id     <= id;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_mul_seq_arb.sv
// Scoreboard bench for nios2_mul_seq_arb with a behavioural registered 16x16 multiplier.
module tb_nios2_mul_seq_arb;

  localparam int unsigned L = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        resp_valid, resp_id;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_result;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;

  nios2_mul_seq_arb #(.MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: not reset, so stale products stay in flight across a DUT reset
  logic [31:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= 32'(mul_a) * 32'(mul_b);
    for (int i = 1; i < int'(L); i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[L-1];

  typedef struct {
    logic        id;
    logic [63:0] res;
    int          hs;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [63:0] ea, eb, r;
    ea = op[0] ? {{32{a[31]}}, a} : {32'd0, a};
    eb = op[1] ? {{32{b[31]}}, b} : {32'd0, b};
    r  = ea * eb;
    if (op[2]) r[63:32] = 32'd0;
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
`ifdef NIOS2_MUL_SEQ_LOWONLY_SHORT_EN
    if (op[2]) return 5 + int'(L);
`endif
    return 6 + int'(L);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic drive_req(input logic rid, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [63:0] res);
    exp_t e;
    bit   got = 0;
    @(negedge clk);
    if (rid) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (rid ? req1_ready : req0_ready) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL req%0d_grant: no ready within bound", rid);
    end else begin
      e.id = rid; e.res = res; e.hs = cyc; e.lat = exp_lat(op);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    exp_t e;
    bit   seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_resp: resp_valid never rose", name);
      return;
    end
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s_sb: response with empty scoreboard", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (resp_result !== e.res) begin
      failures++;
      $display("FAIL %s_result: got %h want %h", name, resp_result, e.res);
    end
    checks++;
    if (resp_id !== e.id) begin
      failures++;
      $display("FAIL %s_id: got %0d want %0d", name, resp_id, e.id);
    end
    checks++;
    if (cyc - e.hs !== e.lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d want %0d", name, cyc - e.hs, e.lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp_flags: valid=%b id=%b want 0 0", resp_valid, resp_id);
    end
    checks++;
    if (resp_result !== 64'd0) begin
      failures++;
      $display("FAIL reset_result: got %h want 0", resp_result);
    end
    checks++;
    if (mul_a !== 16'd0 || mul_b !== 16'd0) begin
      failures++;
      $display("FAIL reset_mul: a=%h b=%h want 0 0", mul_a, mul_b);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_idle: r0=%b r1=%b want 0 0", req0_ready, req1_ready);
    end
    // Both valid then withdrawn before the edge: priority must favour req0, no grant taken
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_prio: r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_basic();
    drive_req(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 64'hFFFF_FFFE_0000_0001);
    wait_resp("uu_max");
    drive_req(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_resp("ss_neg");
    drive_req(1'b0, 32'h8000_0000, 32'h0000_0002, 3'b001, 64'hFFFF_FFFF_0000_0000);
    wait_resp("su_min");
    drive_req(1'b0, 32'h8000_0000, 32'h0000_0002, 3'b101, 64'h0);
    wait_resp("low_only");
    drive_req(1'b1, 32'h1234_5678, 32'h0000_0010, 3'b100, 64'h0000_0000_2345_6780);
    wait_resp("low_only_trunc");
  endtask

  task automatic test_random();
    logic        rid;
    logic [31:0] a, b;
    logic [2:0]  op;
    for (int n = 0; n < 8; n++) begin
      rid = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      op  = 3'($urandom_range(0, 7));
      drive_req(rid, a, b, op, ref_mul(a, b, op));
      wait_resp("random");
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   order [4];
    int   gcyc [4];
    int   ngrant = 0;
    int   nresp = 0;
    int   g;
    do_reset();
    req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 3));
    req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 3));
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 200 && nresp < 4; i++) begin
      @(negedge clk);
      #1;
      g = -1;
      checks++;
      if (req0_ready && req1_ready) begin
        failures++;
        $display("FAIL b2b_dual_ready: both ready in cycle %0d", cyc);
      end
      if (req0_ready && ngrant < 4) begin
        e.id = 1'b0; e.res = ref_mul(req0_a, req0_b, req0_op); e.hs = cyc; e.lat = exp_lat(req0_op);
        sb.push_back(e);
        order[ngrant] = 0; gcyc[ngrant] = cyc; ngrant++; g = 0;
      end else if (req1_ready && ngrant < 4) begin
        e.id = 1'b1; e.res = ref_mul(req1_a, req1_b, req1_op); e.hs = cyc; e.lat = exp_lat(req1_op);
        sb.push_back(e);
        order[ngrant] = 1; gcyc[ngrant] = cyc; ngrant++; g = 1;
      end
      if (resp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL b2b_sb: response with empty scoreboard");
        end else begin
          e = sb.pop_front();
          if (resp_result !== e.res || resp_id !== e.id) begin
            failures++;
            $display("FAIL b2b_resp: got id=%0d %h want id=%0d %h", resp_id, resp_result, e.id, e.res);
          end
        end
        nresp++;
      end
      @(posedge clk);
      #1;
      if (g == 0) begin
        req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 3));
      end else if (g == 1) begin
        req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 3));
      end
      if (ngrant == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    checks++;
    if (nresp != 4 || ngrant != 4) begin
      failures++;
      $display("FAIL b2b_count: grants=%0d resps=%0d want 4 4", ngrant, nresp);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != i % 2) begin
          failures++;
          $display("FAIL b2b_order[%0d]: got %0d want %0d", i, order[i], i % 2);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (gcyc[i] - gcyc[i-1] != 7 + int'(L)) begin
          failures++;
          $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, gcyc[i] - gcyc[i-1], 7 + int'(L));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t        e;
    bit          seen = 0;
    logic [63:0] want;
    do_reset();
    want = ref_mul(32'hDEAD_BEEF, 32'hCAFE_F00D, 3'b011);
    resp_ready = 1'b0;
    drive_req(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3'b011, want);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_resp: resp_valid never rose");
      resp_ready = 1'b1;
      return;
    end
    req0_valid = 1'b1; req0_a = 32'd11; req0_b = 32'd13; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 32'd7;  req1_b = 32'd9;  req1_op = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== want || resp_id !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: v=%b id=%0d %h want 1 0 %h", i, resp_valid, resp_id, resp_result, want);
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || mul_a !== 16'd0 || mul_b !== 16'd0) begin
        failures++;
        $display("FAIL bp_quiet[%0d]: r0=%b r1=%b ma=%h mb=%h want all 0", i, req0_ready, req1_ready, mul_a, mul_b);
      end
    end
    resp_ready = 1'b1;
    void'(sb.pop_front());
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: v=%b r0=%b r1=%b want 0 0 1", resp_valid, req0_ready, req1_ready);
    end
    if (req1_ready) begin
      e.id = 1'b1; e.res = 64'd63; e.hs = cyc; e.lat = exp_lat(3'b000);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp("bp_follow");
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h9ABC_DEF0; req0_op = 3'b011;
    #1;
    got = req0_ready;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rm_grant: req0_ready=0 want 1");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mul_a !== 16'h5678 || mul_b !== 16'h9ABC) begin
      failures++;
      $display("FAIL rm_k2: ma=%h mb=%h want 5678 9abc", mul_a, mul_b);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_result !== 64'd0 || resp_id !== 1'b0 || mul_a !== 16'd0 || mul_b !== 16'd0) begin
      failures++;
      $display("FAIL rm_abort: v=%b id=%b r=%h ma=%h mb=%h want all 0", resp_valid, resp_id, resp_result, mul_a, mul_b);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_prio: r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drive_req(1'b1, 32'd3, 32'd5, 3'b000, 64'd15);
    wait_resp("rm_follow");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time bound expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
